// File: rtl/jkcnt_pkg.sv
// jkcnt_pkg: JK operation encodings and the next-state to J/K mapping
// shared by jk_updown_counter and jk_cell.
package jkcnt_pkg;

  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_CLR  = 2'b01,
    JK_SET  = 2'b10,
    JK_TOG  = 2'b11
  } jk_op_e;

  function automatic jk_op_e jk_op(
    input logic cur,
    input logic nxt
  );
    jk_op_e op;
    op = JK_HOLD;
    unique case (1'b1)
      (cur == nxt):  op = JK_HOLD;
      (~cur & nxt):  op = JK_SET;
      (cur & ~nxt):  op = JK_CLR;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// jk_cell: single JK flip-flop with synchronous active-low clear.
module jk_cell
  import jkcnt_pkg::*;
(
  input  logic clk,
  input  logic clr_n,
  input  logic j,
  input  logic k,
  output logic q
);

  jk_op_e op;
  assign op = jk_op_e'({j, k});

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      q <= 1'b0;
    end else begin
      unique case (op)
        JK_HOLD: q <= q;
        JK_CLR:  q <= 1'b0;
        JK_SET:  q <= 1'b1;
        JK_TOG:  q <= ~q;
      endcase
    end
  end

endmodule

// File: rtl/jk_updown_counter.sv
// jk_updown_counter: modulo-MOD up/down counter built from JK cells.
// Define JKCNT_SATURATE_EN to saturate at the ends instead of wrapping.
module jk_updown_counter
  import jkcnt_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD - 1);
  localparam logic [16:0]      MODV = 17'(MOD);
  localparam logic [WIDTH-1:0] ZERO = '0;

`ifdef JKCNT_SATURATE_EN
  localparam logic [WIDTH-1:0] UP_END = MAXV;
  localparam logic [WIDTH-1:0] DN_END = ZERO;
`else
  localparam logic [WIDTH-1:0] UP_END = ZERO;
  localparam logic [WIDTH-1:0] DN_END = MAXV;
`endif

  logic             at_top;
  logic             at_bot;
  logic             d_over;
  logic [WIDTH-1:0] nxt;

  assign at_top = (q == MAXV);
  assign at_bot = (q == ZERO);
  assign d_over = ({{(17 - WIDTH){1'b0}}, d} >= MODV);
  assign tc     = en & ~load & ((up & at_top) | (~up & at_bot));

  // Clear is applied inside each cell, so nxt ignores clr_n.
  always_comb begin
    nxt = q;
    if (load) begin
      nxt = d_over ? MAXV : d;
    end else if (en) begin
      if (up) begin
        nxt = at_top ? UP_END : q + WIDTH'(1);
      end else begin
        nxt = at_bot ? DN_END : q - WIDTH'(1);
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_op_e op;
    assign op = jk_op(q[i], nxt[i]);

    jk_cell u_cell (
      .clk   (clk),
      .clr_n (clr_n),
      .j     (op[1]),
      .k     (op[0]),
      .q     (q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      wrap <= 1'b0;
    end else begin
      wrap <= tc;
    end
  end

endmodule
